imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RV32I/RV64I front end.
- Decodes all immediate formats (I, S, B, U, J), including the shift-amount special case, and sign-extends to XLEN.
- Carries a pass-through tag and counts illegal opcodes.
- Sits between instruction fetch/decode and execute, using a valid/ready handshake and a 2-entry skid buffer.
- Latency is 1 cycle; throughput is 1 instruction per cycle.

Parameters:
- XLEN, 32, datapath width of imm_out; legal values are 32 and 64.
- TAG_W, 8, width of the opaque tag carried with each instruction.
- SHAMT_ZEXT, 1, 1: shift-immediate ops output a zero-extended shamt; 0: treat as a plain I-type.
- CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and tag are valid.
- in_ready  out  1  block can accept this cycle.
- instruction  in  32  raw instruction word.
- tag_in  in  TAG_W  opaque tag, passed through unchanged.
- out_valid  out  1  output payload is valid.
- out_ready  in  1  consumer accepts this cycle.
- imm_out  out  XLEN  extended immediate.
- imm_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
- imm_illegal  out  1  opcode is not recognised.
- tag_out  out  TAG_W  tag matching imm_out.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, imm_out=0, imm_fmt=0, imm_illegal=0, tag_out=0, illegal_count=0. Both skid entries are emptied.
- in_ready is 0 while reset is high and 1 on the first cycle after reset is released.
- Reset mid-stream discards all buffered entries; nothing is emitted afterwards.

Handshakes:
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- in_ready is a registered value: it equals "skid entry empty". It never depends combinationally on out_ready.

Data path and latency:
- Decode is combinational on the input; the result is registered into the main output register.
- An instruction accepted in cycle N is presented on the outputs in cycle N+1.

Backpressure:
- If the output is stalled (out_valid && !out_ready) and a transfer is accepted, the payload goes into the skid entry.
- in_ready drops on the next cycle.
- When the output drains, the skid entry moves to the output register, and in_ready returns 1 on the following cycle.
- No loss, no duplication, strict order.
- While stalled, all output payload signals hold stable.

Simultaneous events:
- Output drain plus new input in the same cycle with the skid empty: the new payload loads the output register directly, keeping throughput at 1 per cycle.
- Drain with the skid full: skid moves to output, and the skid becomes empty.

Decode (opcode = instruction[6:0]; sign bit = instruction[31], replicated to XLEN):
- 0000011, 0001111, 0010011, 1100111, 1110011 → I: sign-extended instr[31:20].
- Shift ops with SHAMT_ZEXT=1 (opcode 0010011 with funct3 001 or 101) → SHAMT: zero-extended shamt.
  - Shamt is instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
- 0100011 → S: {instr[31:25], instr[11:7]}, sign-extended.
- 1100011 → B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
- 0110111, 0010111 → U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
- 1101111 → J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
- 0110011 → NONE: imm_out=0, imm_illegal=0.
- Any other opcode → NONE: imm_out=0, imm_illegal=1.

Illegal counter:
- Increments once per accepted illegal instruction, at input acceptance time, not output time.
- Saturates at 2^CNT_W−1 and never wraps.

Test Plan:
- Sign extension and tags (XLEN=32, out_ready=1):
  - 0xFFF00093 → imm_out=0xFFFFFFFF, fmt=1, one cycle after accept.
  - 0xFE112E23 → imm_out=0xFFFFFFFC, fmt=2.
  - tag_out equals tag_in for each.
- J and U formats:
  - 0x0010006F → imm_out=0x00000800, fmt=5.
  - 0x123452B7 → imm_out=0x12345000, fmt=4.
  - With XLEN=64, 0x800002B7 → imm_out=0xFFFFFFFF80000000.
- Shift immediates: 0x41F0D093 (srai x1,x1,31).
  - SHAMT_ZEXT=1 → imm_out=0x1F, fmt=6.
  - SHAMT_ZEXT=0 → imm_out=0x0000041F, fmt=1.
- Backpressure:
  - Drive 4 back-to-back valid instructions with tags 1..4 while out_ready=0 → 2 accepted, in_ready=0 from the 3rd cycle.
  - Release out_ready → outputs tags 1..4 in order, no duplicates.
  - Output payload is stable throughout the stall.
- Illegal opcodes:
  - 0x0000007F → imm_out=0, fmt=0, imm_illegal=1, illegal_count += 1.
  - 0x00000033 → imm_illegal=0.
  - With CNT_W=2, 5 illegal instructions → illegal_count=3.
- Reset mid-stream:
  - Assert reset with both entries full → next cycle out_valid=0, illegal_count=0, in_ready=0.
  - After release → in_ready=1; no stale output appears.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined RV32I/RV64I immediate generator. Each accepted instruction is
//   decoded combinationally (I, S, B, U, J, shift-amount) and sign-extended to
//   XLEN. The result is registered, so it appears one cycle after acceptance.
//   A single skid entry behind the output register absorbs one transfer while
//   the consumer stalls. Together the two entries sustain one instruction per
//   cycle, and in_ready stays a pure register output.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready == skid entry empty)
//   instruction       raw 32-bit instruction word
//   tag_in            opaque tag carried alongside the instruction
//   out_valid/out_ready output handshake
//   imm_out           extended immediate (XLEN bits)
//   imm_fmt           0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
//   imm_illegal       opcode not recognised
//   tag_out           tag belonging to imm_out
//   illegal_count     saturating count of accepted illegal instructions
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 8,
    parameter int SHAMT_ZEXT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [TAG_W-1:0] tag_out,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } payload_t;

    // Every format is built as a 64-bit sign-extended value and then cut to
    // XLEN, which avoids zero-width replications when XLEN is 32.
    function automatic payload_t decode_instr(input logic [31:0] instr,
                                              input logic [TAG_W-1:0] tag);
        payload_t    p;
        logic [63:0] imm64;
        logic        sgn;
        logic        is_shift;
        sgn      = instr[31];
        imm64    = 64'd0;
        is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
        p.fmt    = FMT_NONE;
        p.ill    = 1'b0;
        p.tag    = tag;
        case (instr[6:0])
            OP_IMM: begin
                if ((SHAMT_ZEXT != 0) && is_shift) begin
                    if (XLEN == 64) begin
                        imm64 = {58'd0, instr[25:20]};
                    end else begin
                        imm64 = {59'd0, instr[24:20]};
                    end
                    p.fmt = FMT_SHAMT;
                end else begin
                    imm64 = {{52{sgn}}, instr[31:20]};
                    p.fmt = FMT_I;
                end
            end
            OP_LOAD, OP_FENCE, OP_JALR, OP_SYSTEM: begin
                imm64 = {{52{sgn}}, instr[31:20]};
                p.fmt = FMT_I;
            end
            OP_STORE: begin
                imm64 = {{52{sgn}}, instr[31:25], instr[11:7]};
                p.fmt = FMT_S;
            end
            OP_BRANCH: begin
                imm64 = {{51{sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
                p.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm64 = {{32{sgn}}, instr[31:12], 12'd0};
                p.fmt = FMT_U;
            end
            OP_JAL: begin
                imm64 = {{43{sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
                p.fmt = FMT_J;
            end
            OP_REG: begin
                imm64 = 64'd0;
                p.fmt = FMT_NONE;
            end
            default: begin
                imm64 = 64'd0;
                p.ill = 1'b1;
            end
        endcase
        p.imm = imm64[XLEN-1:0];
        return p;
    endfunction

    payload_t         dec_s;
    payload_t         out_pl_r;
    payload_t         skid_pl_r;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r;

    logic             in_fire_s;
    logic             out_free_s;
    logic             out_load_s;
    logic             out_from_skid_s;
    logic             skid_load_s;
    logic             out_valid_nxt_s;
    logic             skid_valid_nxt_s;

    // Decode of whatever is on the input port this cycle.
    always_comb begin
        dec_s = decode_instr(instruction, tag_in);
    end

    // Handshake steering: where the next payload goes and the next entry states.
    always_comb begin
        in_fire_s        = in_valid && in_ready_r;
        out_free_s       = !out_valid_r || out_ready;
        out_load_s       = 1'b0;
        out_from_skid_s  = 1'b0;
        skid_load_s      = 1'b0;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (out_free_s) begin
            // in_ready is low whenever the skid is full, so a held skid entry
            // and a new input can never compete for the output register.
            if (skid_valid_r) begin
                out_load_s       = 1'b1;
                out_from_skid_s  = 1'b1;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (in_fire_s) begin
                out_load_s      = 1'b1;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_load_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_load_s = 1'b0;
            end
        end
    end

    // Output register, skid entry and the registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
            out_pl_r     <= '{imm: {XLEN{1'b0}}, fmt: 3'd0, ill: 1'b0, tag: {TAG_W{1'b0}}};
            skid_pl_r    <= '{imm: {XLEN{1'b0}}, fmt: 3'd0, ill: 1'b0, tag: {TAG_W{1'b0}}};
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            if (out_load_s) begin
                out_pl_r <= out_from_skid_s ? skid_pl_r : dec_s;
            end else begin
                out_pl_r <= out_pl_r;
            end
            if (skid_load_s) begin
                skid_pl_r <= dec_s;
            end else begin
                skid_pl_r <= skid_pl_r;
            end
        end
    end

    // Illegal-opcode counter, bumped at acceptance and held at its maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (in_fire_s && dec_s.ill && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign imm_out       = out_pl_r.imm;
    assign imm_fmt       = out_pl_r.fmt;
    assign imm_illegal   = out_pl_r.ill;
    assign tag_out       = out_pl_r.tag;
    assign illegal_count = cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Three instances share one stimulus stream:
//     a: XLEN=32 SHAMT_ZEXT=1 CNT_W=16
//     b: XLEN=64 SHAMT_ZEXT=1 CNT_W=2
//     c: XLEN=32 SHAMT_ZEXT=0 CNT_W=16
//   A negedge monitor keeps per-instance expectation queues built from an
//   arithmetic reference decoder. A fixed vector table, hand sequences for
//   stall, reset and saturation, and a random phase drive the instances.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [7:0]  tag_in;
    logic        out_ready;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] imm_a, imm_c;
    logic [63:0] imm_b;
    logic [2:0]  fmt_a, fmt_b, fmt_c;
    logic        ill_a, ill_b, ill_c;
    logic [7:0]  tag_a, tag_b, tag_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_ZEXT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .instruction(instruction), .tag_in(tag_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .imm_out(imm_a), .imm_fmt(fmt_a),
        .imm_illegal(ill_a), .tag_out(tag_a), .illegal_count(cnt_a));

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHAMT_ZEXT(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .instruction(instruction), .tag_in(tag_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .imm_out(imm_b), .imm_fmt(fmt_b),
        .imm_illegal(ill_b), .tag_out(tag_b), .illegal_count(cnt_b));

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_ZEXT(0), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
        .instruction(instruction), .tag_in(tag_in), .out_valid(out_valid_c),
        .out_ready(out_ready), .imm_out(imm_c), .imm_fmt(fmt_c),
        .imm_illegal(ill_c), .tag_out(tag_c), .illegal_count(cnt_c));

    // Uniform views of the three instances.
    logic [63:0] imm_o [3];
    logic [2:0]  fmt_o [3];
    logic        ill_o [3];
    logic [7:0]  tag_o [3];
    logic        ov_o  [3];
    logic        ir_o  [3];
    logic [15:0] cnt_o [3];
    assign imm_o[0] = {32'd0, imm_a};
    assign imm_o[1] = imm_b;
    assign imm_o[2] = {32'd0, imm_c};
    assign fmt_o[0] = fmt_a;  assign fmt_o[1] = fmt_b;  assign fmt_o[2] = fmt_c;
    assign ill_o[0] = ill_a;  assign ill_o[1] = ill_b;  assign ill_o[2] = ill_c;
    assign tag_o[0] = tag_a;  assign tag_o[1] = tag_b;  assign tag_o[2] = tag_c;
    assign ov_o[0]  = out_valid_a; assign ov_o[1] = out_valid_b; assign ov_o[2] = out_valid_c;
    assign ir_o[0]  = in_ready_a;  assign ir_o[1] = in_ready_b;  assign ir_o[2] = in_ready_c;
    assign cnt_o[0] = cnt_a;
    assign cnt_o[1] = {14'd0, cnt_b};
    assign cnt_o[2] = cnt_c;

    localparam int XL   [3] = '{32, 64, 32};
    localparam bit ZX   [3] = '{1'b1, 1'b1, 1'b0};
    localparam int CMAX [3] = '{65535, 3, 65535};

    typedef struct {
        longint unsigned imm;
        int              fmt;
        bit              ill;
        bit [7:0]        tag;
    } exp_t;

    exp_t qs [3][$];
    int   mcnt [3];

    task automatic chk(input string name, input int d, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h expected=%h", name, d, act, exp);
        end
    endtask

    // Reference decoder: extract each field with shifts/masks, then
    // sign-correct by subtracting 2^width when the top bit is set.
    function automatic exp_t ref_model(input bit [31:0] ins, input bit [7:0] tg,
                                       input int xlen, input bit zext);
        exp_t   e;
        longint v;
        int     op;
        int     f3;
        op = int'(ins & 32'h7F);
        f3 = int'((ins >> 12) & 32'h7);
        v = 0; e.fmt = 0; e.ill = 1'b0; e.tag = tg;
        if (op inside {3, 15, 19, 103, 115}) begin
            if (zext && op == 19 && (f3 == 1 || f3 == 5)) begin
                v = longint'((ins >> 20) % xlen);
                e.fmt = 6;
            end else begin
                v = longint'(ins >> 20);
                if (v >= 2048) v = v - 4096;
                e.fmt = 1;
            end
        end else if (op == 35) begin
            v = longint'(((ins >> 25) << 5) + ((ins >> 7) & 32'h1F));
            if (v >= 2048) v = v - 4096;
            e.fmt = 2;
        end else if (op == 99) begin
            v = longint'(((ins >> 31) & 1) * 4096 + ((ins >> 7) & 1) * 2048 +
                         ((ins >> 25) & 63) * 32 + ((ins >> 8) & 15) * 2);
            if (v >= 4096) v = v - 8192;
            e.fmt = 3;
        end else if (op == 55 || op == 23) begin
            v = longint'(ins & 32'hFFFFF000);
            if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
            e.fmt = 4;
        end else if (op == 111) begin
            v = longint'(((ins >> 31) & 1) * 1048576 + ((ins >> 12) & 255) * 4096 +
                         ((ins >> 20) & 1) * 2048 + ((ins >> 21) & 1023) * 2);
            if (v >= 1048576) v = v - 2097152;
            e.fmt = 5;
        end else if (op == 51) begin
            v = 0;
        end else begin
            e.ill = 1'b1;
        end
        if (xlen == 32) v = v & 64'sh00000000FFFFFFFF;
        e.imm = longint'(v);
        return e;
    endfunction

    // Scoreboard: outputs are compared with the queue head every cycle they
    // are valid (so stalled payloads must hold), popped on transfer; counters
    // are compared every cycle; accepted inputs are pushed after.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                qs[d].delete();
                mcnt[d] = 0;
            end
        end else begin
            for (int d = 1; d < 3; d++) begin
                chk("in_ready_agree", d, ir_o[d], ir_o[0]);
            end
            for (int d = 0; d < 3; d++) begin
                if (ov_o[d]) begin
                    checks++;
                    if (qs[d].size() == 0) begin
                        failures++;
                        $display("FAIL spurious_output dut%0d actual=tag %h expected=no output",
                                 d, tag_o[d]);
                    end else begin
                        chk("sb_imm", d, imm_o[d], qs[d][0].imm);
                        chk("sb_fmt", d, fmt_o[d], qs[d][0].fmt);
                        chk("sb_ill", d, ill_o[d], qs[d][0].ill);
                        chk("sb_tag", d, tag_o[d], qs[d][0].tag);
                        if (out_ready) void'(qs[d].pop_front());
                    end
                end
                chk("illegal_count", d, cnt_o[d], mcnt[d]);
                if (in_valid && ir_o[d]) begin
                    exp_t e;
                    e = ref_model(instruction, tag_in, XL[d], ZX[d]);
                    qs[d].push_back(e);
                    if (e.ill && mcnt[d] < CMAX[d]) mcnt[d]++;
                end
            end
        end
    end

    task automatic send(input bit [31:0] ins, input bit [7:0] tg);
        in_valid    = 1'b1;
        instruction = ins;
        tag_in      = tg;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (in_ready_a) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_timeout dut0 actual=in_ready stuck low expected=accept within 64 cycles");
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (qs[0].size() == 0 && qs[1].size() == 0 && qs[2].size() == 0) break;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) chk(name, d, qs[d].size(), 0);
    endtask

    typedef struct {
        bit [31:0] ins;
        bit [63:0] imm_a;
        bit [63:0] imm_b;
        bit [63:0] imm_c;
        int        fmt_ab;
        int        fmt_c;
        bit        ill;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF, 1, 1, 1'b0};
        tbl[1] = '{32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFC, 2, 2, 1'b0};
        tbl[2] = '{32'h0010006F, 64'h800, 64'h800, 64'h800, 5, 5, 1'b0};
        tbl[3] = '{32'h123452B7, 64'h12345000, 64'h12345000, 64'h12345000, 4, 4, 1'b0};
        tbl[4] = '{32'h800002B7, 64'h80000000, 64'hFFFFFFFF80000000, 64'h80000000, 4, 4, 1'b0};
        tbl[5] = '{32'h41F0D093, 64'h1F, 64'h1F, 64'h41F, 6, 1, 1'b0};
        tbl[6] = '{32'h02509093, 64'h05, 64'h25, 64'h25, 6, 1, 1'b0};
        tbl[7] = '{32'h80000063, 64'hFFFFF000, 64'hFFFFFFFFFFFFF000, 64'hFFFFF000, 3, 3, 1'b0};
        tbl[8] = '{32'h0000007F, 64'h0, 64'h0, 64'h0, 0, 0, 1'b1};
        tbl[9] = '{32'h00000033, 64'h0, 64'h0, 64'h0, 0, 0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; instruction = 32'd0; tag_in = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_out_valid", d, ov_o[d], 0);
            chk("rst_imm", d, imm_o[d], 0);
            chk("rst_fmt", d, fmt_o[d], 0);
            chk("rst_ill", d, ill_o[d], 0);
            chk("rst_tag", d, tag_o[d], 0);
            chk("rst_count", d, cnt_o[d], 0);
            chk("rst_in_ready", d, ir_o[d], 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 0, in_ready_a, 1);

        // Fixed vectors, one at a time, one-cycle latency.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instruction = tbl[i].ins; tag_in = 8'(i + 16); out_ready = 1'b1;
            @(negedge clk);
            chk("tbl_in_ready", i, in_ready_a, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            #2;
            chk("tbl_valid_a", i, out_valid_a, 1);
            chk("tbl_imm_a", i, imm_a, tbl[i].imm_a);
            chk("tbl_imm_b", i, imm_b, tbl[i].imm_b);
            chk("tbl_imm_c", i, imm_c, tbl[i].imm_c);
            chk("tbl_fmt_a", i, fmt_a, tbl[i].fmt_ab);
            chk("tbl_fmt_b", i, fmt_b, tbl[i].fmt_ab);
            chk("tbl_fmt_c", i, fmt_c, tbl[i].fmt_c);
            chk("tbl_ill_a", i, ill_a, tbl[i].ill);
            chk("tbl_tag_a", i, tag_a, i + 16);
            chk("tbl_tag_b", i, tag_b, i + 16);
            @(posedge clk); #1;
        end
        drain("tbl_drain");

        // Backpressure: four instructions against a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'h00100093; tag_in = 8'd1;
        @(posedge clk); #1;
        chk("bp_ready_cycle2", 0, in_ready_a, 1);
        instruction = 32'h00200093; tag_in = 8'd2;
        @(posedge clk); #1;
        chk("bp_ready_cycle3", 0, in_ready_a, 0);
        instruction = 32'h00300093; tag_in = 8'd3;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_ready_held", 0, in_ready_a, 0);
            chk("bp_accepted", 0, qs[0].size(), 2);
            chk("bp_tag_stable", 0, tag_a, 1);
        end
        out_ready = 1'b1;
        send(32'h00300093, 8'd3);
        send(32'h00400093, 8'd4);
        drain("bp_drain");

        // Reset with both entries occupied.
        out_ready = 1'b0;
        send(32'h0000007F, 8'd5);
        send(32'h00000013, 8'd6);
        chk("mid_full", 0, in_ready_a, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk("mid_rst_valid", d, ov_o[d], 0);
            chk("mid_rst_count", d, cnt_o[d], 0);
            chk("mid_rst_ready", d, ir_o[d], 0);
        end
        reset = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_release_ready", 0, in_ready_a, 1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("mid_no_stale", 0, out_valid_a, 0);
        end

        // Five illegal instructions: 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) send(32'h0000007F, 8'(40 + i));
        @(posedge clk); #1;
        chk("sat_count_a", 0, cnt_a, 5);
        chk("sat_count_b", 1, cnt_b, 3);
        drain("sat_drain");

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit [6:0] ops [11];
            bit [31:0] r;
            int k;
            ops = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
            r = $urandom();
            k = $urandom_range(0, 12);
            in_valid    = ($urandom_range(0, 2) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            instruction = (k < 11) ? {r[31:7], ops[k]} : r;
            tag_in      = 8'($urandom());
            @(posedge clk); #1;
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
